tagged_demultiplexer: RTL and testbench
=======================================

Name: tagged_demultiplexer

Overview:
- Routing stage on the opposite side of the tagged stream fabric from the tag-filtering multiplexer.
- Takes one tagged input stream (tagged_i) and steers each beat to one of NUM_OUTPUTS plain data streams (data_i), selected by the beat's tag.
- Optionally broadcasts end-of-stream to every output, so each downstream consumer sees its own last marker.
- One registered slot per output: 1-cycle latency, full throughput per output.

Parameters:
- data_t, none (type), payload type carried on all ports.
- NUM_OUTPUTS, 4, number of output streams; tag value i routes to out[i].
- TAG_WIDTH, 2, width of in.tag; must satisfy 2**TAG_WIDTH >= NUM_OUTPUTS.
- LAST_HANDLING, 1: 0 = BROADCAST, every output gets a last marker; 1 = FORWARD, last travels only with its beat.
- FILTER_KEEP, 1: 1 = beats with keep=0 are not written to an output (their last still counts); 0 = forward all beats.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in  tagged_i.s  data_t+TAG_WIDTH+3  input stream (data, keep, last, tag, valid, ready).
- out[NUM_OUTPUTS]  data_i.m  data_t+3 each  output streams (data, keep, last, valid, ready).
- drop_cnt  out  32  count of beats with out-of-range tags; present only with the optional feature.

Behaviour:
- Reset: all out[i].valid=0, keep=0, last=0; FSM=PASS; pending mask=0; drop_cnt=0. Data fields are don't-care.
- Slot i is free when !out[i].valid || out[i].ready. Slot i loads on a clock edge only when free, so out[i] holds data/keep/last stable while valid && !ready.
- FSM PASS:
  - in.ready = free(tag) when tag < NUM_OUTPUTS; 1 when tag >= NUM_OUTPUTS (the beat is dropped).
  - An accepted beat with tag t loads slot t: data, keep, last (last=in.last in FORWARD; in.last in BROADCAST as well).
  - In FILTER_KEEP mode with keep=0: the slot is not loaded, the beat is consumed, and in.ready = free(t) still applies when last=1 in BROADCAST mode.
  - BROADCAST with an accepted in.last: pending = all outputs except t (or all outputs if the beat was filtered or dropped). Next state is BCAST.
- FSM BCAST:
  - in.ready=0.
  - Each cycle, every pending output whose slot is free loads a dummy beat (keep=0, last=1) and clears its pending bit. Multiple outputs may load in the same cycle.
  - When pending becomes 0 after the update, next state is PASS. New input is accepted no earlier than the cycle after.
- Latency: accept edge to out.valid is 1 cycle. A slot can sustain 1 beat/cycle under continuous ready (combinational ready path from out[t].ready to in.ready).
- Simultaneous events: a slot draining and loading on the same edge is legal. Only one output loads from the input per cycle.
- Reset mid-operation: clears all slots and the FSM at once. Partially broadcast last markers are discarded.
- NUM_OUTPUTS=1: the degenerate case is legal. BROADCAST pending is always empty unless the beat was filtered.

Optional Feature:
- Macro TAGGED_DEMUX_DROP_CNT_EN.
- Defined: drop_cnt port exists. It increments (saturating at 2^32-1) on every accepted beat with tag >= NUM_OUTPUTS, and resets to 0.
- Undefined: no port and no counter. Out-of-range beats are silently consumed.

Decomposition:
- Shared package (stream_pkg) holds:
  - LAST_HANDLING constants LAST_BROADCAST=0, LAST_FORWARD=1, shared with the multiplexer;
  - demux FSM state enum {PASS, BCAST}.
- Natural sub-module: demux_output_slot. One-entry register with load/free/hold logic, instantiated NUM_OUTPUTS times.

Test Plan:
- FORWARD, NUM_OUTPUTS=4, all ready: beats with tags 0,1,2,3,1 and data 10..14 → out[0]=10, out[1]=11,14, out[2]=12, out[3]=13, each 1 cycle after accept, no bubbles.
- Backpressure: out[2].ready=0 for 5 cycles, two tag-2 beats sent → first held stable on out[2], in.ready=0 for the second. A tag-0 beat arriving behind it waits (in-order), then both drain once ready=1.
- BROADCAST: a tag-1 beat with last=1, data 0x55, all ready → out[1] gets 0x55 last=1. The next cycle out[0], out[2], out[3] get keep=0 last=1. in.ready=0 during BCAST and 1 one cycle later.
- BROADCAST with out[3].ready=0 for 4 cycles → out[3] dummy delayed until ready; in.ready stays 0 until the out[3] dummy is loaded.
- FILTER_KEEP=1: tag-0 beat with keep=0, last=0 → no out valid. With keep=0, last=1 in BROADCAST → all 4 outputs get a dummy last.
- TAGGED_DEMUX_DROP_CNT_EN with NUM_OUTPUTS=3: 7 beats with tag 3 → all consumed with in.ready=1, no out valid, drop_cnt=7. After reset, drop_cnt=0.

Source files
------------

// File: rtl/tagged_demultiplexer_pkg.sv
// Shared stream-fabric definitions: last-marker handling modes and the demux FSM state.
package tagged_demultiplexer_pkg;

    localparam int LAST_BROADCAST = 0;
    localparam int LAST_FORWARD   = 1;

    typedef enum logic [0:0] {
        DEMUX_PASS  = 1'b0,
        DEMUX_BCAST = 1'b1
    } demux_state_e;

endpackage

// File: rtl/tagged_demultiplexer_output_slot.sv
// One-entry output register: loads only when free, holds its contents while valid && !ready.
module tagged_demultiplexer_output_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  keep_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  free_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  keep_o,
    output logic                  last_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  keep_q, keep_d;
    logic                  last_q, last_d;

    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load_i && free_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/tagged_demultiplexer.sv
// Steers each tagged input beat to the output selected by its tag, optionally broadcasting last.
// Optional out-of-range drop counter enabled by TAGGED_DEMUX_DROP_CNT_EN.
module tagged_demultiplexer
    import tagged_demultiplexer_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_OUTPUTS   = 4,
    parameter int TAG_WIDTH     = 2,
    parameter int LAST_HANDLING = LAST_FORWARD,
    parameter int FILTER_KEEP   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH-1:0]                 in_data_i,
    input  logic                                  in_keep_i,
    input  logic                                  in_last_i,
    input  logic [TAG_WIDTH-1:0]                  in_tag_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_data_o,
    output logic [NUM_OUTPUTS-1:0]                out_keep_o,
    output logic [NUM_OUTPUTS-1:0]                out_last_o,
    output logic [NUM_OUTPUTS-1:0]                out_valid_o,
    input  logic [NUM_OUTPUTS-1:0]                out_ready_i
`ifdef TAGGED_DEMUX_DROP_CNT_EN
    ,
    output logic [31:0]                           drop_cnt_o
`endif
);

    demux_state_e           state_q, state_d;
    logic [NUM_OUTPUTS-1:0] pending_q, pending_d;
    logic [NUM_OUTPUTS-1:0] free_s;
    logic [NUM_OUTPUTS-1:0] tag_hit_s;
    logic [NUM_OUTPUTS-1:0] load_s;
    logic                   tag_in_range_s;
    logic                   filtered_s;
    logic                   accept_s;
    logic [DATA_WIDTH-1:0]  slot_data_s;
    logic                   slot_keep_s;
    logic                   slot_last_s;

    // An out-of-range tag decodes to an all-zero hit vector.
    always_comb begin
        tag_hit_s = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            tag_hit_s[i] = (in_tag_i == TAG_WIDTH'(i));
        end
    end

    assign tag_in_range_s = |tag_hit_s;
    assign filtered_s     = (FILTER_KEEP != 0) && !in_keep_i;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        load_s      = '0;
        in_ready_o  = 1'b0;
        accept_s    = 1'b0;
        slot_data_s = in_data_i;
        slot_keep_s = in_keep_i;
        slot_last_s = in_last_i;
        case (state_q)
            DEMUX_PASS: begin
                if (tag_in_range_s) begin
                    in_ready_o = |(tag_hit_s & free_s);
                end else begin
                    in_ready_o = 1'b1;
                end
                accept_s = in_valid_i && in_ready_o;
                if (accept_s && tag_in_range_s && !filtered_s) begin
                    load_s = tag_hit_s;
                end else begin
                    load_s = '0;
                end
                // Filtered or dropped last beats still owe a marker to every output.
                if (accept_s && in_last_i && (LAST_HANDLING == LAST_BROADCAST)) begin
                    pending_d = {NUM_OUTPUTS{1'b1}} & ~load_s;
                    if (pending_d != '0) begin
                        state_d = DEMUX_BCAST;
                    end else begin
                        state_d = DEMUX_PASS;
                    end
                end else begin
                    pending_d = pending_q;
                    state_d   = DEMUX_PASS;
                end
            end
            DEMUX_BCAST: begin
                slot_data_s = '0;
                slot_keep_s = 1'b0;
                slot_last_s = 1'b1;
                load_s      = pending_q & free_s;
                pending_d   = pending_q & ~free_s;
                if (pending_d == '0) begin
                    state_d = DEMUX_PASS;
                end else begin
                    state_d = DEMUX_BCAST;
                end
            end
            default: begin
                state_d   = DEMUX_PASS;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= DEMUX_PASS;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_slot
        tagged_demultiplexer_output_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load_s[g]),
            .data_i  (slot_data_s),
            .keep_i  (slot_keep_s),
            .last_i  (slot_last_s),
            .ready_i (out_ready_i[g]),
            .free_o  (free_s[g]),
            .valid_o (out_valid_o[g]),
            .data_o  (out_data_o[g]),
            .keep_o  (out_keep_o[g]),
            .last_o  (out_last_o[g])
        );
    end

`ifdef TAGGED_DEMUX_DROP_CNT_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept_s && !tag_in_range_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= 32'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tagged_demultiplexer.sv
// Directed scoreboard bench: FORWARD (4 outputs), BROADCAST (4 outputs) and FORWARD (3 outputs) instances.
module tb_tagged_demultiplexer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_data;
    logic       in_keep, in_last, in_valid;
    logic [1:0] in_tag;
    logic [3:0] out_ready;
    logic [1:0] sel;

    logic [3:0][7:0] f_data, b_data;
    logic [3:0]      f_valid, f_keep, f_last, b_valid, b_keep, b_last;
    logic [2:0][7:0] n_data;
    logic [2:0]      n_valid, n_keep, n_last;
    logic            f_rdy, b_rdy, n_rdy;
    logic            f_in_valid, b_in_valid, n_in_valid;
`ifdef TAGGED_DEMUX_DROP_CNT_EN
    logic [31:0]     f_drop, b_drop, n_drop;
`endif

    assign f_in_valid = in_valid && (sel == 2'd0);
    assign b_in_valid = in_valid && (sel == 2'd1);
    assign n_in_valid = in_valid && (sel == 2'd2);

    tagged_demultiplexer #(.DATA_WIDTH(8), .NUM_OUTPUTS(4), .TAG_WIDTH(2), .LAST_HANDLING(1), .FILTER_KEEP(1)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
        .in_tag_i(in_tag), .in_valid_i(f_in_valid), .in_ready_o(f_rdy),
        .out_data_o(f_data), .out_keep_o(f_keep), .out_last_o(f_last), .out_valid_o(f_valid),
        .out_ready_i(out_ready)
`ifdef TAGGED_DEMUX_DROP_CNT_EN
        , .drop_cnt_o(f_drop)
`endif
    );

    tagged_demultiplexer #(.DATA_WIDTH(8), .NUM_OUTPUTS(4), .TAG_WIDTH(2), .LAST_HANDLING(0), .FILTER_KEEP(1)) dut_bc (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
        .in_tag_i(in_tag), .in_valid_i(b_in_valid), .in_ready_o(b_rdy),
        .out_data_o(b_data), .out_keep_o(b_keep), .out_last_o(b_last), .out_valid_o(b_valid),
        .out_ready_i(out_ready)
`ifdef TAGGED_DEMUX_DROP_CNT_EN
        , .drop_cnt_o(b_drop)
`endif
    );

    tagged_demultiplexer #(.DATA_WIDTH(8), .NUM_OUTPUTS(3), .TAG_WIDTH(2), .LAST_HANDLING(1), .FILTER_KEEP(1)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
        .in_tag_i(in_tag), .in_valid_i(n_in_valid), .in_ready_o(n_rdy),
        .out_data_o(n_data), .out_keep_o(n_keep), .out_last_o(n_last), .out_valid_o(n_valid),
        .out_ready_i(out_ready[2:0])
`ifdef TAGGED_DEMUX_DROP_CNT_EN
        , .drop_cnt_o(n_drop)
`endif
    );

    logic [3:0]      obs_valid, obs_keep, obs_last;
    logic [3:0][7:0] obs_data;
    logic            obs_in_ready;

    always_comb begin
        obs_valid    = '0;
        obs_keep     = '0;
        obs_last     = '0;
        obs_data     = '0;
        obs_in_ready = 1'b0;
        case (sel)
            2'd0: begin
                obs_valid = f_valid; obs_keep = f_keep; obs_last = f_last;
                obs_data = f_data; obs_in_ready = f_rdy;
            end
            2'd1: begin
                obs_valid = b_valid; obs_keep = b_keep; obs_last = b_last;
                obs_data = b_data; obs_in_ready = b_rdy;
            end
            default: begin
                obs_valid = {1'b0, n_valid}; obs_keep = {1'b0, n_keep}; obs_last = {1'b0, n_last};
                obs_data[2:0] = n_data; obs_in_ready = n_rdy;
            end
        endcase
    end

    typedef struct {
        logic [7:0] data;
        logic       keep;
        logic       last;
        bit         chk_data;
    } exp_t;

    exp_t q[4][$];
    int   checks   = 0;
    int   failures = 0;
    int   stall_left = 0;
    logic [3:0] stall_mask = 4'b0000;
    int   w;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        assert (got === req) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", name, got, req);
        end
    endtask

    // Pop and compare every output that completes a handshake at the coming edge.
    task automatic sb_check();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rst_n && obs_valid[i] && out_ready[i]) begin
                check("sb_has_entry", 32'(q[i].size() != 0), 32'd1);
                if (q[i].size() != 0) begin
                    e = q[i].pop_front();
                    check("sb_keep", 32'(obs_keep[i]), 32'(e.keep));
                    check("sb_last", 32'(obs_last[i]), 32'(e.last));
                    if (e.chk_data) begin
                        check("sb_data", 32'(obs_data[i]), 32'(e.data));
                    end
                end
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        sb_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) out_ready = out_ready | stall_mask;
        end
    endtask

    // Expected outputs of one accepted beat, derived from the mode of the selected instance.
    task automatic model_accept(input logic [1:0] tag, input logic [7:0] data, input logic keep, input logic last);
        int  nout;
        bit  loaded;
        nout   = (sel == 2'd2) ? 3 : 4;
        loaded = (int'(tag) < nout) && keep;
        if (loaded) q[tag].push_back('{data, keep, last, 1'b1});
        if ((sel == 2'd1) && last) begin
            for (int i = 0; i < nout; i++) begin
                if (!(loaded && (i == int'(tag)))) q[i].push_back('{8'h00, 1'b0, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic send(input logic [1:0] tag, input logic [7:0] data, input logic keep, input logic last,
                        output int waits);
        bit done;
        in_tag = tag; in_data = data; in_keep = keep; in_last = last; in_valid = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done && waits < 20) begin
            at_neg();
            waits++;
            if (obs_in_ready) begin
                done = 1'b1;
                model_accept(tag, data, keep, last);
            end
            at_pos();
        end
        in_valid = 1'b0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic drain(input string name);
        int left;
        repeat (3) begin
            at_neg();
            at_pos();
        end
        left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
        check(name, 32'(left), 32'd0);
    endtask

    initial begin
        logic [1:0] tags [5];
        tags[0] = 2'd0; tags[1] = 2'd1; tags[2] = 2'd2; tags[3] = 2'd3; tags[4] = 2'd1;
        rst_n = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0; in_tag = 2'd0;
        in_valid = 1'b0; out_ready = 4'hF; sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 32'({f_valid, b_valid, n_valid}), 32'd0);
        check("rst_keep", 32'({f_keep, b_keep, n_keep}), 32'd0);
        check("rst_last", 32'({f_last, b_last, n_last}), 32'd0);
        check("rst_in_ready", 32'({f_rdy, b_rdy, n_rdy}), 32'b111);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FORWARD routing, all outputs ready, back-to-back beats.
        sel = 2'd0;
        for (int k = 0; k < 5; k++) begin
            send(tags[k], 8'(10 + k), 1'b1, 1'b0, w);
            check("fwd_no_bubble", 32'(w), 32'd1);
        end
        at_neg();
        check("fwd_latency_valid", 32'(obs_valid), 32'b0010);
        check("fwd_latency_data", 32'(obs_data[1]), 32'd14);
        at_pos();
        drain("fwd_drained");

        // Backpressure on out[2]: first beat held, second blocked, tag-0 beat behind it.
        out_ready[2] = 1'b0;
        stall_mask   = 4'b0100;
        stall_left   = 5;
        send(2'd2, 8'h20, 1'b1, 1'b0, w);
        at_neg();
        check("bp_hold_valid", 32'(obs_valid[2]), 32'd1);
        check("bp_hold_data", 32'(obs_data[2]), 32'h20);
        check("bp_in_ready_low", 32'(obs_in_ready), 32'd0);
        at_pos();
        send(2'd2, 8'h21, 1'b1, 1'b0, w);
        check("bp_second_wait", 32'(w), 32'd4);
        send(2'd0, 8'h22, 1'b1, 1'b0, w);
        check("bp_tag0_wait", 32'(w), 32'd1);
        drain("bp_drained");

        // BROADCAST last, all ready.
        sel = 2'd1;
        send(2'd1, 8'h55, 1'b1, 1'b1, w);
        at_neg();
        check("bc_first_valid", 32'(obs_valid), 32'b0010);
        check("bc_ready_in_bcast", 32'(obs_in_ready), 32'd0);
        at_pos();
        at_neg();
        check("bc_dummy_valid", 32'(obs_valid), 32'b1101);
        check("bc_ready_after", 32'(obs_in_ready), 32'd1);
        at_pos();
        drain("bc_drained");

        // BROADCAST with out[3] occupied and stalled.
        out_ready[3] = 1'b0;
        send(2'd3, 8'h30, 1'b1, 1'b0, w);
        send(2'd1, 8'h31, 1'b1, 1'b1, w);
        repeat (3) begin
            at_neg();
            check("bc_stall_ready_low", 32'(obs_in_ready), 32'd0);
            at_pos();
        end
        out_ready[3] = 1'b1;
        at_neg();
        check("bc_stall_ready_still_low", 32'(obs_in_ready), 32'd0);
        at_pos();
        at_neg();
        check("bc_stall_dummy3", 32'({obs_valid[3], obs_keep[3], obs_last[3]}), 32'b101);
        check("bc_stall_ready_back", 32'(obs_in_ready), 32'd1);
        at_pos();
        drain("bc_stall_drained");

        // Keep filtering: plain filtered beat vanishes, filtered last broadcasts to all.
        send(2'd0, 8'h66, 1'b0, 1'b0, w);
        at_neg();
        check("filt_no_valid", 32'(obs_valid), 32'd0);
        at_pos();
        send(2'd0, 8'h77, 1'b0, 1'b1, w);
        at_neg();
        check("filt_last_bcast_ready", 32'(obs_in_ready), 32'd0);
        check("filt_last_none_yet", 32'(obs_valid), 32'd0);
        at_pos();
        at_neg();
        check("filt_last_all_dummies", 32'(obs_valid), 32'hF);
        at_pos();
        drain("filt_drained");

        // Reset in the middle of a broadcast discards the remaining markers.
        out_ready[2] = 1'b0;
        send(2'd2, 8'h40, 1'b1, 1'b0, w);
        send(2'd0, 8'h41, 1'b1, 1'b1, w);
        at_neg();
        at_pos();
        rst_n = 1'b0;
        at_neg();
        at_pos();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        at_neg();
        check("midrst_valid", 32'(obs_valid), 32'd0);
        check("midrst_in_ready", 32'(obs_in_ready), 32'd1);
        at_pos();
        out_ready[2] = 1'b1;

        // Three outputs: tag 3 is out of range and silently consumed.
        sel = 2'd2;
        for (int k = 0; k < 7; k++) begin
            send(2'd3, 8'(k), 1'b1, 1'b0, w);
            check("drop_ready", 32'(w), 32'd1);
        end
        at_neg();
        check("drop_no_valid", 32'(obs_valid), 32'd0);
`ifdef TAGGED_DEMUX_DROP_CNT_EN
        check("drop_cnt", n_drop, 32'd7);
`endif
        at_pos();
        send(2'd2, 8'h99, 1'b1, 1'b0, w);
        drain("n3_drained");
`ifdef TAGGED_DEMUX_DROP_CNT_EN
        rst_n = 1'b0;
        at_pos();
        rst_n = 1'b1;
        at_neg();
        check("drop_cnt_reset", n_drop, 32'd0);
        at_pos();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
